// File: rtl/jtag_debug_cmd_queue.sv
// Clock-domain side of the JTAG debug command path: synchronises TCK-domain update
// strobes and queues decoded DR captures for the CPU-side debug logic.
module jtag_debug_cmd_queue #(
  parameter int IR_W         = 2,
  parameter int DATA_W       = 38,
  parameter int NUM_CH       = 4,
  parameter int DEPTH        = 4,
  parameter int TAKE_BIT     = 37,
  parameter int FLUSH_ON_UIR = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [IR_W-1:0]            ir_in,
  input  logic [DATA_W-1:0]          sr,
  input  logic                       vs_udr,
  input  logic                       vs_uir,
  output logic                       act_valid,
  input  logic                       act_ready,
  output logic [IR_W-1:0]            act_ch,
  output logic                       act_take,
  output logic [DATA_W-1:0]          jdo,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       uir_pulse,
  input  logic                       clr_status,
  output logic                       err_overflow,
  output logic                       err_badch
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [IR_W:0] NUM_CH_W = (IR_W+1)'(NUM_CH);

  logic [2:0]        udrSync_q, uirSync_q;
  logic [1:0]        arm_q;
  logic [AW:0]       wr_q, rd_q, wr_d, rd_d, level_d;
  logic [DATA_W-1:0] headData_q, headData_d;
  logic [IR_W-1:0]   headCh_q, headCh_d;
  logic              uirPulse_q, errOvf_q, errOvf_d, errBad_q, errBad_d;
  logic [DATA_W-1:0] memData [DEPTH];
  logic [IR_W-1:0]   memCh   [DEPTH];

  logic armed, udrEvt, uirEvt, full, pop, flush, badCh, pushReq, push, ovfEvt;

  // Events are held off until the arm counter saturates, so a strobe already high at
  // reset release is absorbed rather than treated as a fresh update.
  assign armed  = (arm_q == 2'd3);
  assign udrEvt = armed & udrSync_q[1] & ~udrSync_q[2];
  assign uirEvt = armed & uirSync_q[1] & ~uirSync_q[2];

  assign level     = wr_q - rd_q;
  assign act_valid = (level != '0);
  assign full      = (level == FULL_LVL);
  assign pop       = act_valid & act_ready;
  assign flush     = (FLUSH_ON_UIR != 0) & uirEvt;
  assign badCh     = ({1'b0, ir_in} >= NUM_CH_W);
  assign pushReq   = udrEvt & ~badCh;
  assign push      = pushReq & (~full | pop | flush);
  assign ovfEvt    = pushReq & ~push;

  // The head is registered so it holds its last value once the queue drains.
  always_comb begin
    rd_d       = rd_q;
    wr_d       = wr_q;
    headData_d = headData_q;
    headCh_d   = headCh_q;
    if (flush)     rd_d = wr_q;
    else if (pop)  rd_d = rd_q + PTR_ONE;
    if (push)      wr_d = wr_q + PTR_ONE;
    level_d = wr_d - rd_d;
    if (level_d != '0) begin
      if (push && (wr_q[AW-1:0] == rd_d[AW-1:0])) begin
        headData_d = sr;
        headCh_d   = ir_in;
      end else begin
        headData_d = memData[rd_d[AW-1:0]];
        headCh_d   = memCh[rd_d[AW-1:0]];
      end
    end
    errOvf_d = (errOvf_q & ~clr_status) | ovfEvt;
    errBad_d = (errBad_q & ~clr_status) | (udrEvt & badCh);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udrSync_q  <= '0;
      uirSync_q  <= '0;
      arm_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      headData_q <= '0;
      headCh_q   <= '0;
      uirPulse_q <= 1'b0;
      errOvf_q   <= 1'b0;
      errBad_q   <= 1'b0;
    end else begin
      udrSync_q  <= {udrSync_q[1:0], vs_udr};
      uirSync_q  <= {uirSync_q[1:0], vs_uir};
      if (!armed) arm_q <= arm_q + 2'd1;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      headData_q <= headData_d;
      headCh_q   <= headCh_d;
      uirPulse_q <= uirEvt;
      errOvf_q   <= errOvf_d;
      errBad_q   <= errBad_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      memData[wr_q[AW-1:0]] <= sr;
      memCh[wr_q[AW-1:0]]   <= ir_in;
    end
  end

  assign jdo          = headData_q;
  assign act_ch       = headCh_q;
  assign act_take     = headData_q[TAKE_BIT];
  assign uir_pulse    = uirPulse_q;
  assign err_overflow = errOvf_q;
  assign err_badch    = errBad_q;

endmodule

// File: tb/tb_jtag_debug_cmd_queue.sv
// Directed bench for jtag_debug_cmd_queue: a flushing 3-channel instance plus a
// non-flushing twin driven by the same stimulus.
module tb_jtag_debug_cmd_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        vs_udr, vs_uir, act_ready, clr_status;

  logic        actValid, actTake, uirPulse, errOverflow, errBadch;
  logic [1:0]  actCh;
  logic [37:0] jdoOut;
  logic [2:0]  levelOut;

  logic        nfValid, nfTake, nfUirPulse, nfOverflow, nfBadch;
  logic [1:0]  nfCh;
  logic [37:0] nfJdo;
  logic [2:0]  nfLevel;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jtag_debug_cmd_queue #(.NUM_CH(3), .FLUSH_ON_UIR(1)) dut (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
    .vs_udr(vs_udr), .vs_uir(vs_uir), .act_valid(actValid), .act_ready(act_ready),
    .act_ch(actCh), .act_take(actTake), .jdo(jdoOut), .level(levelOut),
    .uir_pulse(uirPulse), .clr_status(clr_status),
    .err_overflow(errOverflow), .err_badch(errBadch)
  );

  jtag_debug_cmd_queue #(.NUM_CH(3), .FLUSH_ON_UIR(0)) dutNf (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
    .vs_udr(vs_udr), .vs_uir(vs_uir), .act_valid(nfValid), .act_ready(act_ready),
    .act_ch(nfCh), .act_take(nfTake), .jdo(nfJdo), .level(nfLevel),
    .uir_pulse(nfUirPulse), .clr_status(clr_status),
    .err_overflow(nfOverflow), .err_badch(nfBadch)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Four-cycle vs_udr pulse; popAtEvt raises act_ready exactly in the push cycle.
  task automatic applyStimulus(input logic [1:0] ir, input logic [37:0] data,
                               input bit popAtEvt);
    ir_in  = ir;
    sr     = data;
    vs_udr = 1'b1;
    tick();
    tick();
    if (popAtEvt) act_ready = 1'b1;
    tick();
    act_ready = 1'b0;
    tick();
    vs_udr = 1'b0;
    repeat (3) tick();
  endtask

  task automatic popOne();
    act_ready = 1'b1;
    tick();
    act_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; vs_udr = 1'b1; vs_uir = 1'b0;
    ir_in = '0; sr = '0; act_ready = 1'b0; clr_status = 1'b0;

    repeat (3) tick();
    checkOutput("rst_valid", actValid, 0);
    checkOutput("rst_level", levelOut, 0);
    checkOutput("rst_jdo", jdoOut, 0);
    checkOutput("rst_ch", actCh, 0);
    checkOutput("rst_uir", uirPulse, 0);
    checkOutput("rst_flags", {errOverflow, errBadch}, 0);
    reset_n = 1'b1;
    repeat (10) tick();
    checkOutput("arm_level", levelOut, 0);
    checkOutput("arm_valid", actValid, 0);
    vs_udr = 1'b0;
    repeat (4) tick();

    ir_in = 2'd2; sr = 38'h20_0000_1234; vs_udr = 1'b1;
    tick();
    checkOutput("single_valid_k", actValid, 0);
    tick();
    checkOutput("single_valid_k1", actValid, 0);
    tick();
    checkOutput("single_valid_k2", actValid, 1);
    checkOutput("single_ch", actCh, 2);
    checkOutput("single_take", actTake, 1);
    checkOutput("single_jdo", jdoOut, 38'h20_0000_1234);
    checkOutput("single_level", levelOut, 1);
    tick();
    vs_udr = 1'b0;
    repeat (3) tick();
    checkOutput("single_hold_jdo", jdoOut, 38'h20_0000_1234);
    popOne();
    checkOutput("single_pop_valid", actValid, 0);
    checkOutput("single_pop_level", levelOut, 0);
    checkOutput("single_last_jdo", jdoOut, 38'h20_0000_1234);

    for (int i = 1; i <= 4; i++) applyStimulus(2'd1, 38'(i), 1'b0);
    checkOutput("ovf_level4", levelOut, 4);
    checkOutput("ovf_flag_pre", errOverflow, 0);
    applyStimulus(2'd1, 38'd5, 1'b0);
    checkOutput("ovf_level", levelOut, 4);
    checkOutput("ovf_flag", errOverflow, 1);
    checkOutput("ovf_take", actTake, 0);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("ovf_drain_jdo", jdoOut, 64'(i));
      popOne();
    end
    checkOutput("ovf_drained", levelOut, 0);
    checkOutput("ovf_flag_kept", errOverflow, 1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    checkOutput("ovf_cleared", errOverflow, 0);

    applyStimulus(2'd3, 38'h55, 1'b0);
    checkOutput("bad_level", levelOut, 0);
    checkOutput("bad_flag", errBadch, 1);
    checkOutput("bad_no_ovf", errOverflow, 0);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    checkOutput("bad_cleared", errBadch, 0);

    for (int i = 0; i < 4; i++) applyStimulus(2'd0, 38'h11 + 38'(i), 1'b0);
    checkOutput("pp_full", levelOut, 4);
    applyStimulus(2'd1, 38'h15, 1'b1);
    checkOutput("pp_level", levelOut, 4);
    checkOutput("pp_no_ovf", errOverflow, 0);
    checkOutput("pp_head", jdoOut, 38'h12);
    popOne();
    checkOutput("pp_d13", jdoOut, 38'h13);
    popOne();
    checkOutput("pp_d14", jdoOut, 38'h14);
    popOne();
    checkOutput("pp_d15", jdoOut, 38'h15);
    checkOutput("pp_ch15", actCh, 1);
    popOne();
    checkOutput("pp_empty", levelOut, 0);

    applyStimulus(2'd0, 38'h21, 1'b0);
    applyStimulus(2'd0, 38'h22, 1'b0);
    checkOutput("fl_level_pre", levelOut, 2);
    vs_uir = 1'b1;
    tick();
    tick();
    checkOutput("fl_pulse_early", uirPulse, 0);
    checkOutput("fl_level_early", levelOut, 2);
    tick();
    checkOutput("fl_pulse", uirPulse, 1);
    checkOutput("fl_level", levelOut, 0);
    checkOutput("fl_valid", actValid, 0);
    checkOutput("fl_nf_level", nfLevel, 2);
    checkOutput("fl_nf_pulse", nfUirPulse, 1);
    tick();
    checkOutput("fl_pulse_end", uirPulse, 0);
    vs_uir = 1'b0;
    repeat (3) tick();

    ir_in = 2'd0; sr = 38'h31; vs_udr = 1'b1; vs_uir = 1'b1;
    repeat (4) tick();
    vs_udr = 1'b0; vs_uir = 1'b0;
    repeat (3) tick();
    checkOutput("both_level", levelOut, 1);
    checkOutput("both_jdo", jdoOut, 38'h31);
    checkOutput("both_nf_level", nfLevel, 3);
    checkOutput("both_nf_head", nfJdo, 38'h21);

    reset_n = 1'b0;
    #1;
    checkOutput("midrst_level", levelOut, 0);
    checkOutput("midrst_nf_level", nfLevel, 0);
    checkOutput("midrst_jdo", jdoOut, 0);
    tick();
    reset_n = 1'b1;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtag_debug_cmd_queue.md
Name: jtag_debug_cmd_queue

Overview:
- Parametrised successor to the sysclk-side half of the Nios II JTAG debug module.
- Synchronises update strobes arriving from the virtual-JTAG/TCK domain into clk.
- On each DR update, captures the scanned shift register and decodes the IR channel. It queues {channel, take/no-take, data} in a small FIFO so the CPU-side debug logic can consume commands under ready/valid backpressure, instead of single-cycle take_action pulses that can be lost.
- Adds a configurable channel count, queue depth, an IR-update flush mode, and sticky error flags.

Parameters:
IR_W, 2, width of ir_in.
DATA_W, 38, width of sr and jdo.
NUM_CH, 4, number of valid command channels; must be <= 2**IR_W.
DEPTH, 4, queue entries; power of two, >= 2.
TAKE_BIT, 37, index of the sr bit that selects take (1) or no-take (0); must be < DATA_W.
FLUSH_ON_UIR, 1, 1 = an IR update empties the queue.

Ports:
clk  in  1  system clock.
reset_n  in  1  reset; asynchronous assert, active-low.
ir_in  in  IR_W  instruction register from TCK domain; stable around vs_udr rise.
sr  in  DATA_W  scan shift register from TCK domain; stable around vs_udr rise.
vs_udr  in  1  virtual update-DR level, asynchronous to clk.
vs_uir  in  1  virtual update-IR level, asynchronous to clk.
act_valid  out  1  queue head is valid.
act_ready  in  1  consumer accepts the head.
act_ch  out  IR_W  channel of the head entry.
act_take  out  1  head entry's take flag (sr[TAKE_BIT] at capture).
jdo  out  DATA_W  head entry's captured data.
level  out  $clog2(DEPTH)+1  queue occupancy.
uir_pulse  out  1  one-cycle pulse per synchronised IR update.
clr_status  in  1  clears sticky flags.
err_overflow  out  1  sticky: an update was dropped because the queue was full.
err_badch  out  1  sticky: an update arrived with ir_in >= NUM_CH.

Behaviour:
- Reset (async, reset_n=0):
  - Sync flops, queue pointers and sticky flags clear.
  - All outputs go to 0: act_valid, act_ch, act_take, jdo, level, uir_pulse, err_overflow, err_badch.
  - A reset asserted mid-operation discards all queued entries.
- Synchroniser:
  - Three flops per strobe: s1 <= in, s2 <= s1, s3 <= s2.
  - udr_evt = s2 & ~s3. uir_evt is formed the same way.
- Arm counter:
  - Counts 3 clk edges after reset release; events are suppressed until it saturates.
  - Effect: a strobe level already high at reset release is absorbed without producing an event.
- Latency: vs_udr first sampled high at edge k -> udr_evt high between k+1 and k+2 -> entry written at k+2 -> act_valid high after k+2 when the queue was empty.
- On udr_evt:
  - ir_in < NUM_CH: push {ir_in, sr[TAKE_BIT], sr}; ir_in/sr are sampled directly in the event cycle (JTAG holds them stable).
  - ir_in >= NUM_CH: no push; err_badch <= 1.
  - Queue full with no pop that cycle: entry dropped; err_overflow <= 1; queue contents unchanged.
- Pop: on act_valid & act_ready the head advances the next cycle. act_ready is ignored while act_valid=0.
- Full with push and pop in the same cycle: both happen; level unchanged.
- Empty with push: act_valid rises the next cycle. There is no same-cycle bypass.
- Head stability: act_ch, act_take and jdo are stable while act_valid=1 and act_ready=0. When act_valid=0 they hold their last value (0 after reset).
- On uir_evt:
  - uir_pulse = 1 for exactly one cycle (registered, aligned with the uir_evt cycle +1).
  - If FLUSH_ON_UIR=1, the queue empties next cycle and level becomes 0.
  - uir_evt and udr_evt in the same cycle: flush first, then the new entry is pushed, so level = 1.
- Status flags:
  - clr_status=1 clears both sticky flags next cycle.
  - If an error event coincides with clr_status, the flag is set (set wins).
- Pointers: read/write pointers wrap modulo DEPTH. level = write count minus read count, range 0..DEPTH.

Test Plan:
- Reset check: hold reset_n=0 with vs_udr=1 -> all outputs 0. Release -> no entry ever appears (arm counter absorbs the level); level stays 0.
- Single command: ir_in=2, sr=38'h20_0000_1234, pulse vs_udr high 4 cycles, act_ready=0 -> act_valid rises 3 edges after first sample; act_ch=2, act_take=1, jdo=38'h20_0000_1234. Then act_ready=1 for 1 cycle -> act_valid=0, level=0.
- Backpressure/overflow: with DEPTH=4, act_ready=0, issue 5 updates with data 1..5 -> level=4, err_overflow=1. Draining yields jdo=1,2,3,4 in order; 5 is lost. clr_status then clears err_overflow.
- Bad channel: NUM_CH=3, ir_in=3 update -> no push, err_badch=1, level unchanged.
- Full with simultaneous push and pop: queue holding 4 entries, act_ready=1 in the same cycle as udr_evt -> level stays 4, no overflow, new entry appears last.
- Flush: 2 entries queued, vs_uir pulse -> uir_pulse one cycle, level=0, act_valid=0. With FLUSH_ON_UIR=0 the same stimulus leaves level=2.
